instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_pkg.sv | 24 ++
 rtl/instruction_fetch_if.sv | 25 ++
 rtl/instruction_fetch_perf_counters.sv | 30 +++
 rtl/instruction_fetch.sv | 138 +++++++++++++
 tb/tb_instruction_fetch.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   fetch_state_e    : fetch FSM state encoding (BOOT / RUN / HALT)
//   NOP_WORD_DEFAULT : default bubble word inserted into IF/ID
//   PC_STEP          : byte increment between sequential fetches
//   word_index()     : byte address -> word index ({2'b00, addr[31:2]})
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Instruction-memory bus between the fetch stage and a combinational memory.
//   imem_addr : word index driven by the fetch stage
//   imem_data : instruction word returned combinationally by the memory
// Modports:
//   master : fetch stage (drives imem_addr, consumes imem_data)
//   slave  : instruction memory (consumes imem_addr, drives imem_data)
// -----------------------------------------------------------------------------
interface instruction_fetch_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_data;

    modport master (
        output imem_addr,
        input  imem_data
    );

    modport slave (
        input  imem_addr,
        output imem_data
    );

endinterface

// File: rtl/instruction_fetch_perf_counters.sv
// -----------------------------------------------------------------------------
// fetch_perf_counters
// Free-running fetch/stall event counters, wrapping at 2^32.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   fetch_inc    : one-cycle pulse per edge that captures a real instruction
//   stall_inc    : one-cycle pulse per stalled RUN edge
//   fetch_count  : number of captured instructions
//   stall_count  : number of stalled RUN edges
// -----------------------------------------------------------------------------
module fetch_perf_counters (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (fetch_inc) fetch_count <= fetch_count + 32'd1;
            if (stall_inc) stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Owns the program counter, drives the word address into a combinational
// instruction memory and registers the returned word plus its PC+4 into the
// IF/ID pipeline register. Honours stall and redirect, and halts when the PC
// leaves the populated memory range.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   stall         : hold PC and IF/ID
//   redirect      : taken branch/jump, load redirect_pc (overrides stall)
//   redirect_pc   : byte target, bits [1:0] ignored
//   imem          : instruction memory bus (master side)
//   id_instr      : IF/ID instruction
//   id_pc_plus4   : IF/ID PC+4 (byte address)
//   id_valid      : IF/ID holds a real instruction
//   halted        : high while in HALT
//   fetch_count   : (FETCH_PERF_CNT_EN only) captured instructions
//   stall_count   : (FETCH_PERF_CNT_EN only) stalled RUN edges
//
// Build option: define FETCH_PERF_CNT_EN to add the performance counters.
//
// state | meaning
// ------+------------------------------------------------------------
// BOOT  | first cycle after reset, PC held, IF/ID loads a bubble
// RUN   | fetching one word per cycle, honouring redirect then stall
// HALT  | PC out of range, bubbles only, waits for an in-range redirect
// -----------------------------------------------------------------------------
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 128,
    parameter logic [31:0] NOP_WORD   = NOP_WORD_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_pc,
    instruction_fetch_if.master imem,
    output logic [31:0]         id_instr,
    output logic [31:0]         id_pc_plus4,
    output logic                id_valid,
    output logic                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]         fetch_count,
    output logic [31:0]         stall_count
`endif
);

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  redirect_target;
    logic         pc_out_of_range;
    logic         target_out_of_range;

    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign pc_out_of_range     = word_index(pc) >= IMEM_DEPTH;
    assign target_out_of_range = word_index(redirect_target) >= IMEM_DEPTH;

    assign imem.imem_addr = word_index(pc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            id_instr    <= NOP_WORD;
            id_pc_plus4 <= 32'd0;
            id_valid    <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    id_instr <= NOP_WORD;
                    id_valid <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        pc       <= redirect_target;
                        id_instr <= NOP_WORD;
                        id_valid <= 1'b0;
                    end else if (pc_out_of_range) begin
                        // never capture a word from beyond the populated range
                        id_instr <= NOP_WORD;
                        id_valid <= 1'b0;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else if (!stall) begin
                        id_instr    <= imem.imem_data;
                        id_pc_plus4 <= pc + PC_STEP;
                        id_valid    <= 1'b1;
                        pc          <= pc + PC_STEP;
                    end
                end
                HALT: begin
                    id_instr <= NOP_WORD;
                    id_valid <= 1'b0;
                    if (redirect) begin
                        // an out-of-range target is still loaded so imem_addr
                        // reflects where software tried to go
                        pc <= redirect_target;
                        if (!target_out_of_range) begin
                            halted <= 1'b0;
                            state  <= RUN;
                        end
                    end
                end
                default: begin
                    id_instr <= NOP_WORD;
                    id_valid <= 1'b0;
                    halted   <= 1'b0;
                    state    <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = (state == RUN) && !redirect && !pc_out_of_range && !stall;
    assign stall_inc = (state == RUN) && stall && !redirect;

    fetch_perf_counters u_perf (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_inc   (fetch_inc),
        .stall_inc   (stall_inc),
        .fetch_count (fetch_count),
        .stall_count (stall_count)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
// Directed bench for instruction_fetch with a 128-word combinational memory
// model. Words default to 32'h1000_0000 | index, with words 0, 1, 2, 7
// overridden. Out-of-range reads return 32'hDEADBEEF so any illegal capture
// shows up on id_instr.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    logic [31:0] mem [0:127];

    int passed = 0;
    int total  = 0;

    instruction_fetch_if ifc ();

    assign ifc.imem_data = (ifc.imem_addr < 32'd128) ? mem[ifc.imem_addr[6:0]] : 32'hDEADBEEF;

    instruction_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (ifc.master),
        .id_instr    (id_instr),
        .id_pc_plus4 (id_pc_plus4),
        .id_valid    (id_valid),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count),
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h0023_00AA;
        mem[1] = 32'h1065_4321;
        mem[2] = 32'h0020_0022;
        mem[7] = 32'hAC65_4321;

        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;

        #2;
        check("rst_instr",  id_instr,      32'h0);
        check("rst_pc4",    id_pc_plus4,   32'h0);
        check("rst_valid",  {31'd0, id_valid}, 32'd0);
        check("rst_halted", {31'd0, halted},   32'd0);
        check("rst_addr",   ifc.imem_addr, 32'd0);
        #10 rst_n = 1'b1;

        // BOOT
        tick();
        check("boot_valid", {31'd0, id_valid}, 32'd0);
        check("boot_addr",  ifc.imem_addr, 32'd0);

        // free run
        tick();
        check("run0_instr", id_instr,    32'h0023_00AA);
        check("run0_pc4",   id_pc_plus4, 32'd4);
        check("run0_valid", {31'd0, id_valid}, 32'd1);
        tick();
        check("run1_instr", id_instr,    32'h1065_4321);
        check("run1_pc4",   id_pc_plus4, 32'd8);
        check("run1_addr",  ifc.imem_addr, 32'd2);

        // stall two cycles at pc = 8
        stall = 1'b1;
        tick();
        check("stall0_instr", id_instr,      32'h1065_4321);
        check("stall0_addr",  ifc.imem_addr, 32'd2);
        tick();
        check("stall1_instr", id_instr,      32'h1065_4321);
        check("stall1_addr",  ifc.imem_addr, 32'd2);
        check("stall1_valid", {31'd0, id_valid}, 32'd1);
        stall = 1'b0;
        tick();
        check("unstall_instr", id_instr,    32'h0020_0022);
        check("unstall_pc4",   id_pc_plus4, 32'd12);
        check("unstall_addr",  ifc.imem_addr, 32'd3);

        // redirect to 0x1F at pc = 12
        redirect = 1'b1; redirect_pc = 32'h0000_001F;
        tick();
        check("redir_valid", {31'd0, id_valid}, 32'd0);
        check("redir_instr", id_instr,      32'h0);
        check("redir_addr",  ifc.imem_addr, 32'd7);
        redirect = 1'b0;
        tick();
        check("redir_fetch", id_instr,    32'hAC65_4321);
        check("redir_pc4",   id_pc_plus4, 32'h20);

        // redirect and stall together
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        check("rs_valid", {31'd0, id_valid}, 32'd0);
        check("rs_addr",  ifc.imem_addr, 32'd16);
        stall = 1'b0; redirect = 1'b0;
        tick();
        check("rs_fetch", id_instr,    32'h1000_0010);
        check("rs_pc4",   id_pc_plus4, 32'h44);

        // run off the end of memory
        redirect = 1'b1; redirect_pc = 32'h0000_01F8;
        tick();
        check("end_addr126", ifc.imem_addr, 32'd126);
        redirect = 1'b0;
        tick();
        check("end_w126", id_instr, 32'h1000_007E);
        tick();
        check("end_w127",  id_instr,      32'h1000_007F);
        check("end_pc4",   id_pc_plus4,   32'h200);
        check("end_addr",  ifc.imem_addr, 32'd128);
        check("end_nohalt", {31'd0, halted}, 32'd0);
        tick();
        check("halt_halted", {31'd0, halted},   32'd1);
        check("halt_valid",  {31'd0, id_valid}, 32'd0);
        check("halt_instr",  id_instr,      32'h0);
        check("halt_addr",   ifc.imem_addr, 32'd128);
        tick();
        check("halt2_halted", {31'd0, halted},   32'd1);
        check("halt2_valid",  {31'd0, id_valid}, 32'd0);
        check("halt2_addr",   ifc.imem_addr, 32'd128);

        // out-of-range redirect while halted: stay halted, pc loaded
        redirect = 1'b1; redirect_pc = 32'h0000_0400;
        tick();
        check("halt_oor_halted", {31'd0, halted}, 32'd1);
        check("halt_oor_addr",   ifc.imem_addr,   32'd256);

        // in-range redirect leaves HALT
        redirect_pc = 32'h0000_0000;
        tick();
        check("unhalt_halted", {31'd0, halted},   32'd0);
        check("unhalt_addr",   ifc.imem_addr,     32'd0);
        check("unhalt_valid",  {31'd0, id_valid}, 32'd0);
        redirect = 1'b0;
        tick();
        check("unhalt_fetch", id_instr, 32'h0023_00AA);
        check("unhalt_fvld",  {31'd0, id_valid}, 32'd1);

        // redirect on the same edge the PC crosses out of range
        redirect = 1'b1; redirect_pc = 32'h0000_01FC;
        tick();
        check("edge_addr127", ifc.imem_addr, 32'd127);
        redirect = 1'b0;
        tick();
        check("edge_w127",  id_instr,      32'h1000_007F);
        check("edge_addr",  ifc.imem_addr, 32'd128);
        redirect = 1'b1; redirect_pc = 32'h0000_0010;
        tick();
        check("edge_halted", {31'd0, halted},   32'd0);
        check("edge_tgt",    ifc.imem_addr,     32'd4);
        redirect = 1'b0;
        tick();
        check("edge_fetch", id_instr,      32'h1000_0004);
        check("edge_pc4",   id_pc_plus4,   32'h14);
        check("edge_pc20",  ifc.imem_addr, 32'd5);

        // asynchronous reset mid-RUN at pc = 20
        #2 rst_n = 1'b0;
        #1;
        check("arst_instr", id_instr,      32'h0);
        check("arst_pc4",   id_pc_plus4,   32'h0);
        check("arst_valid", {31'd0, id_valid}, 32'd0);
        check("arst_addr",  ifc.imem_addr, 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("reboot_valid", {31'd0, id_valid}, 32'd0);
        check("reboot_addr",  ifc.imem_addr,     32'd0);

        // five fetches with two stalls in between
        tick();
        check("c_f0", id_instr, 32'h0023_00AA);
        tick();
        check("c_f1", id_instr, 32'h1065_4321);
        stall = 1'b1;
        tick();
        tick();
        check("c_hold", id_instr, 32'h1065_4321);
        stall = 1'b0;
        tick();
        check("c_f2", id_instr, 32'h0020_0022);
        tick();
        check("c_f3", id_instr, 32'h1000_0003);
        tick();
        check("c_f4",  id_instr,    32'h1000_0004);
        check("c_pc4", id_pc_plus4, 32'd20);
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fetch_count, 32'd5);
        check("stall_count", stall_count, 32'd2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
